// File: rtl/image_downsampler.sv
// image_downsampler: 2x2 block pooling of an IMG_W x IMG_H 8-bit image read from a source RAM
// with RD_LAT read latency. Define DS_MAX_POOL_EN for max pooling instead of the rounded average.
module image_downsampler #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write_done,
  output logic [15:0] dram_addr,
  input  logic [7:0]  dram_q,
  output logic [15:0] res_addr,
  output logic [7:0]  res_data,
  output logic        res_wen,
  output logic        busy,
  output logic        retrieve_image
);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

  localparam logic [7:0] LAST_BJ   = 8'(IMG_W / 2 - 1);
  localparam logic [7:0] LAST_BI   = 8'(IMG_H / 2 - 1);
  localparam logic [2:0] CAP_FIRST = 3'(RD_LAT);
  localparam logic [2:0] CAP_LAST  = 3'(RD_LAT + 3);

`ifdef DS_MAX_POOL_EN
  localparam int ACC_W = 8;

  function automatic logic [ACC_W-1:0] pool_step(input logic [ACC_W-1:0] acc,
                                                 input logic [7:0] s, input logic first);
    if (first || (s > acc)) return s;
    return acc;
  endfunction

  function automatic logic [7:0] pool_final(input logic [ACC_W-1:0] acc);
    return acc;
  endfunction
`else
  localparam int ACC_W = 10;

  function automatic logic [ACC_W-1:0] pool_step(input logic [ACC_W-1:0] acc,
                                                 input logic [7:0] s, input logic first);
    if (first) return {2'b00, s};
    return acc + {2'b00, s};
  endfunction

  // Sum of four bytes plus 2 tops out at 1022, so 10 bits never wrap.
  function automatic logic [7:0] pool_final(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] r;
    r = (acc + 10'd2) >> 2;
    return r[7:0];
  endfunction
`endif

  state_t           state_q, state_d;
  logic [2:0]       cyc_q, cyc_d;
  logic [7:0]       bi_q, bi_d, bj_q, bj_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_step;
  logic             wd_prev_q, wd_prev_d;
  logic             armed_q, armed_d;
  logic [15:0]      res_addr_q, res_addr_d;
  logic [7:0]       res_data_q, res_data_d;
  logic             res_wen_q, res_wen_d;
  logic             busy_q, busy_d;
  logic             retrieve_q, retrieve_d;
  logic             capture;
  logic [15:0]      rd_row, rd_col, rd_addr;

  // Within a block, cyc_q[1] selects the odd row and cyc_q[0] the odd column.
  always_comb begin
    rd_row  = {7'd0, bi_q, cyc_q[1]};
    rd_col  = {7'd0, bj_q, cyc_q[0]};
    rd_addr = rd_row * 16'(IMG_W) + rd_col;
  end

  assign dram_addr = (state_q == READ) ? rd_addr : 16'd0;

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    bi_d       = bi_q;
    bj_d       = bj_q;
    acc_d      = acc_q;
    wd_prev_d  = write_done;
    armed_d    = armed_q | ~write_done;
    res_addr_d = res_addr_q;
    res_data_d = res_data_q;
    res_wen_d  = 1'b0;
    busy_d     = busy_q;
    retrieve_d = retrieve_q;
    // Sample k arrives RD_LAT cycles after its address, which may overlap the READ phase.
    capture    = ((state_q == READ) || (state_q == DRAIN)) &&
                 (cyc_q >= CAP_FIRST) && (cyc_q <= CAP_LAST);
    acc_step   = pool_step(acc_q, dram_q, cyc_q == CAP_FIRST);
    if (capture) acc_d = acc_step;

    unique case (state_q)
      IDLE: begin
        // armed_q blocks a start from a write_done that was already high at reset release.
        if (write_done && !wd_prev_q && armed_q) begin
          state_d = READ;
          cyc_d   = 3'd0;
          bi_d    = 8'd0;
          bj_d    = 8'd0;
          busy_d  = 1'b1;
        end
      end
      READ: begin
        cyc_d = cyc_q + 3'd1;
        if (cyc_q == 3'd3) state_d = DRAIN;
      end
      DRAIN: begin
        cyc_d = cyc_q + 3'd1;
        if (cyc_q == CAP_LAST) begin
          state_d    = WRITE;
          res_wen_d  = 1'b1;
          res_addr_d = 16'(bi_q) * 16'(IMG_W / 2) + 16'(bj_q);
          res_data_d = pool_final(acc_step);
        end
      end
      WRITE: begin
        cyc_d = 3'd0;
        if ((bi_q == LAST_BI) && (bj_q == LAST_BJ)) begin
          state_d    = DONE;
          busy_d     = 1'b0;
          retrieve_d = 1'b0;
        end else begin
          state_d = READ;
          if (bj_q == LAST_BJ) begin
            bj_d = 8'd0;
            bi_d = bi_q + 8'd1;
          end else begin
            bj_d = bj_q + 8'd1;
          end
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cyc_q      <= 3'd0;
      bi_q       <= 8'd0;
      bj_q       <= 8'd0;
      acc_q      <= '0;
      wd_prev_q  <= 1'b0;
      armed_q    <= 1'b0;
      res_addr_q <= 16'd0;
      res_data_q <= 8'd0;
      res_wen_q  <= 1'b0;
      busy_q     <= 1'b0;
      retrieve_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bi_q       <= bi_d;
      bj_q       <= bj_d;
      acc_q      <= acc_d;
      wd_prev_q  <= wd_prev_d;
      armed_q    <= armed_d;
      res_addr_q <= res_addr_d;
      res_data_q <= res_data_d;
      res_wen_q  <= res_wen_d;
      busy_q     <= busy_d;
      retrieve_q <= retrieve_d;
    end
  end

  assign res_addr       = res_addr_q;
  assign res_data       = res_data_q;
  assign res_wen        = res_wen_q;
  assign busy           = busy_q;
  assign retrieve_image = retrieve_q;

endmodule
